seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle EX-stage ALU.
- Executes the R-type function set on WIDTH-bit operands. Multiply and divide are iterative, not combinational.
- Adds a remainder op, a full-width multiply high word, divide-by-zero flagging, a valid/ready handshake and a pipeline flush.
- Sits in the EX stage. The decode/hazard logic stalls on in_ready low.

---
 rtl/seq_alu.sv | 183 ++++++++++++++++++
 tb/tb_seq_alu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops, iterative shift-add
// multiply and restoring divide, valid/ready handshake and synchronous flush.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       func_q, func_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
  logic             last_iter;

  function automatic logic [15:0] lane_enc(input logic [15:0] x);
    return {x[7:6], x[3:2], x[9:8], x[13:12], x[1:0], x[15:14], x[5:4], x[11:10]};
  endfunction

  function automatic logic [15:0] lane_dec(input logic [15:0] x);
    return {x[5:4], x[9:8], x[1:0], x[11:10], x[15:14], x[3:2], x[13:12], x[7:6]};
  endfunction

  function automatic logic [WIDTH-1:0] single_op(input logic [3:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (f)
      4'd0, 4'd4: r = a + b;
      4'd1, 4'd5: r = a - b;
      4'd6:       r = a & b;
      4'd7:       r = a | b;
      4'd8:       r = a ^ b;
      4'd9:       r = ~a;
      4'd11: for (int k = 0; k < WIDTH / 16; k++) r[16*k +: 16] = lane_enc(b[16*k +: 16]);
      4'd12: for (int k = 0; k < WIDTH / 16; k++) r[16*k +: 16] = lane_dec(b[16*k +: 16]);
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Multiply keeps {res_hi_q,res_q} as the product/multiplier shift register;
  // divide keeps the dividend/quotient in res_q and the partial remainder in rem_q.
  always_comb begin
    mul_sum     = {1'b0, res_hi_q} + (res_q[0] ? {1'b0, opnd_q} : '0);
    div_shift   = {rem_q, res_q[WIDTH-1]};
    div_trial   = div_shift - {1'b0, opnd_q};
    div_ge      = ~div_trial[WIDTH];
    div_rem_nxt = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_nxt = {res_q[WIDTH-2:0], div_ge};
    last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    cnt_d    = cnt_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          func_d   = func;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          res_hi_d = '0;
          rem_d    = '0;
          if (func == 4'd2) begin
            opnd_d  = op1;
            res_d   = op2;
            state_d = S_MUL;
          end else if (func == 4'd3 || func == 4'd10) begin
            if (op2 == '0) begin
              res_d   = (func == 4'd3) ? '1 : op1;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              opnd_d  = op2;
              res_d   = op1;
              state_d = S_DIV;
            end
          end else begin
            res_d   = single_op(func, op1, op2);
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        res_hi_d = mul_sum[WIDTH:1];
        res_d    = {mul_sum[0], res_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) state_d = S_DONE;
      end
      S_DIV: begin
        rem_d = div_rem_nxt;
        res_d = div_quo_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          res_d   = (func_q == 4'd10) ? div_rem_nxt : div_quo_nxt;
          state_d = S_DONE;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
          dbz_d   = 1'b0;
        end
      end
    endcase

    // Flush wins over accept and over out_ready; the held result is dropped.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      dbz_d    = 1'b0;
      res_d    = '0;
      res_hi_d = '0;
      rem_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      func_q   <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      cnt_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      cnt_q    <= cnt_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = res_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed and random operations on a 16-bit instance,
// encrypt/decrypt round trip on a 32-bit instance, against an arithmetic model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  func = '0;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        div_by_zero;

  logic        in_valid_w = 1'b0;
  logic        in_ready_w;
  logic [3:0]  func_w = '0;
  logic [31:0] op1_w = '0;
  logic [31:0] op2_w = '0;
  logic        out_valid_w;
  logic        out_ready_w = 1'b0;
  logic [31:0] result_w;
  logic [31:0] result_hi_w;
  logic        div_by_zero_w;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .func(func_w), .op1(op1_w), .op2(op2_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .result(result_w), .result_hi(result_hi_w), .div_by_zero(div_by_zero_w)
  );

  // Lane permutation as a pair-index table: encrypted pair p comes from source pair SRC[p].
  function automatic logic [15:0] perm(input logic [15:0] x, input bit dec);
    int src [8] = '{5, 2, 7, 0, 6, 4, 1, 3};
    logic [15:0] y;
    y = '0;
    for (int p = 0; p < 8; p++) begin
      if (!dec) y[2*p +: 2] = x[2*src[p] +: 2];
      else      y[2*src[p] +: 2] = x[2*p +: 2];
    end
    return y;
  endfunction

  // Returns {div_by_zero, hi[31:0], lo[31:0]} for a w-bit ALU.
  function automatic logic [64:0] model(input int w, input logic [3:0] f,
                                        input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, x, y, lo, hi, p;
    bit dz;
    mask = (64'd1 << w) - 64'd1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    lo = 0; hi = 0; dz = 0;
    case (f)
      4'd0, 4'd4: lo = (x + y) & mask;
      4'd1, 4'd5: lo = (x - y) & mask;
      4'd2: begin p = x * y; lo = p & mask; hi = p >> w; end
      4'd3:  if (y == 0) begin lo = mask; dz = 1; end else lo = x / y;
      4'd10: if (y == 0) begin lo = x;    dz = 1; end else lo = x % y;
      4'd6: lo = x & y;
      4'd7: lo = x | y;
      4'd8: lo = x ^ y;
      4'd9: lo = ~x & mask;
      4'd11, 4'd12:
        for (int k = 0; k < w / 16; k++)
          lo = lo | (longint'(perm(y[16*k +: 16], f == 4'd12)) << (16 * k));
      default: lo = 0;
    endcase
    return {dz, hi[31:0], lo[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on the 16-bit DUT; hold = cycles of back-pressure once done.
  task automatic do_op16(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input string tag);
    logic [64:0] m;
    int lat, explat;
    bit busy_ok;
    m = model(16, f, {16'd0, a}, {16'd0, b});
    explat = (f == 4'd2 || ((f == 4'd3 || f == 4'd10) && b != 16'd0)) ? 17 : 1;
    @(negedge clk);
    check({tag, "/ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; func = f; op1 = a; op2 = b;
    @(negedge clk);
    in_valid = 1'b0; func = 4'($urandom); op1 = 16'($urandom); op2 = 16'($urandom);
    lat = 1; busy_ok = 1;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(explat));
    check({tag, "/ready_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "/result"}, 64'(result), 64'(m[15:0]));
    check({tag, "/result_hi"}, 64'(result_hi), 64'(m[47:32]));
    check({tag, "/dbz"}, 64'(div_by_zero), 64'(m[64]));
    check({tag, "/ready_done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "/hold_result"}, 64'(result), 64'(m[15:0]));
      check({tag, "/hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/valid_after"}, 64'(out_valid), 64'd0);
    check({tag, "/dbz_after"}, 64'(div_by_zero), 64'd0);
    check({tag, "/ready_after"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_op32(input logic [3:0] f, input logic [31:0] b, input string tag,
                         output logic [31:0] r);
    logic [64:0] m;
    m = model(32, f, 32'd0, b);
    @(negedge clk);
    in_valid_w = 1'b1; func_w = f; op1_w = $urandom; op2_w = b;
    @(negedge clk);
    in_valid_w = 1'b0;
    check({tag, "/valid"}, 64'(out_valid_w), 64'd1);
    check({tag, "/result"}, 64'(result_w), 64'(m[31:0]));
    r = result_w;
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
  endtask

  initial begin
    logic [31:0] enc, dec;
    logic [3:0]  rf;
    logic [15:0] ra, rb;
    bit seen;

    // Reset state
    #1;
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/result", 64'(result), 64'd0);
    check("rst/dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/in_ready", 64'(in_ready), 64'd1);

    // Directed single-cycle, multiply and divide
    do_op16(4'd0,  16'hFFFF, 16'h0002, 0, "add_wrap");
    do_op16(4'd8,  16'h0F0F, 16'h00FF, 0, "xor");
    do_op16(4'd9,  16'h1234, 16'h5555, 0, "not");
    do_op16(4'd2,  16'hFFFF, 16'hFFFF, 0, "mul_max");
    do_op16(4'd3,  16'd1000, 16'd7,    0, "div_quo");
    do_op16(4'd10, 16'd1000, 16'd7,    0, "div_rem");
    do_op16(4'd3,  16'h1234, 16'h0000, 0, "div0_quo");
    do_op16(4'd10, 16'h1234, 16'h0000, 0, "div0_rem");
    do_op16(4'd1,  16'h0000, 16'h0001, 0, "sub_wrap");
    do_op16(4'd14, 16'hABCD, 16'h1234, 0, "unused_fn");

    // Back-pressure on a finished add
    do_op16(4'd0, 16'h1111, 16'h2222, 5, "backpressure");

    // Flush in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; func = 4'd3; op1 = 16'd1000; op2 = 16'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_div/out_valid", 64'(out_valid), 64'd0);
    check("flush_div/in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("flush_div/never_valid", 64'(seen), 64'd0);

    // Flush together with out_ready and a new request in DONE
    @(negedge clk);
    in_valid = 1'b1; func = 4'd0; op1 = 16'd5; op2 = 16'd6;
    @(negedge clk);
    check("flush_done/valid_before", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("flush_done/out_valid", 64'(out_valid), 64'd0);
    check("flush_done/in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("flush_done/no_accept", 64'(out_valid), 64'd0);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      rf = 4'($urandom_range(15));
      ra = 16'($urandom);
      rb = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
      do_op16(rf, ra, rb, int'($urandom_range(2)), $sformatf("rand%0d_f%0d", i, rf));
    end

    // Async reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; func = 4'd2; op1 = 16'hFFFF; op2 = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mul/out_valid", 64'(out_valid), 64'd0);
    check("rst_mul/result", 64'(result), 64'd0);
    check("rst_mul/result_hi", 64'(result_hi), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mul/in_ready", 64'(in_ready), 64'd1);
    check("rst_mul/out_valid_after", 64'(out_valid), 64'd0);

    // 32-bit encrypt/decrypt round trip
    do_op32(4'd11, 32'hA5C3_1E7F, "enc32", enc);
    check("enc32/lane_hi", 64'(enc[31:16]), 64'(perm(16'hA5C3, 1'b0)));
    check("enc32/lane_lo", 64'(enc[15:0]), 64'(perm(16'h1E7F, 1'b0)));
    do_op32(4'd12, enc, "dec32", dec);
    check("dec32/round_trip", 64'(dec), 64'h0000_0000_A5C3_1E7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
